// File: rtl/week6_ex1_exhaustive_tester.sv
// ---------------------------------------------------------------------------
// week6_ex1_exhaustive_tester
//
// Exhaustive stimulus/response engine for a 7-input, 1-output combinational
// circuit. It walks the input vector 0..127 onto A..G. Each vector is held for
// SETTLE cycles, and then the returned Y is compared with the golden table
// EXPECTED. The block counts mismatches, records the first failing vector,
// and can optionally fold the Y stream into a CRC-16 signature.
//
// Parameters
//   EXPECTED  golden truth table, bit n = expected Y for input vector n
//   SETTLE    cycles each vector is held before Y is sampled (1..15)
//
// Ports
//   clk               sole clock, rising edge
//   rst               synchronous active-high reset
//   start             begin a sweep (honoured in IDLE or DONE only)
//   dut_y             Y returned by the circuit under test
//   A..G              stimulus, A = vec[6] .. G = vec[0]
//   busy              sweep in progress
//   done              sweep complete, held until start or rst
//   pass              done with zero mismatches
//   fail_count        number of mismatching vectors (0..128)
//   first_fail_vec    index of the first mismatching vector
//   first_fail_valid  first_fail_vec holds a captured index
//   signature         CRC-16 (poly 0x1021, seed 0xFFFF) of the Y stream
//
// Build option
//   EXHAUSTIVE_TESTER_SIGNATURE_EN  when defined, the CRC signature logic is
//   built. When it is not defined, signature is tied to 16'h0000.
// ---------------------------------------------------------------------------
module week6_ex1_exhaustive_tester #(
    parameter logic [127:0] EXPECTED = 128'h0,
    parameter int unsigned  SETTLE   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dut_y,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        E,
    output logic        F,
    output logic        G,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  fail_count,
    output logic [6:0]  first_fail_vec,
    output logic        first_fail_valid,
    output logic [15:0] signature
);

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
    localparam logic [6:0] LAST_VEC  = 7'd127;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [6:0]  vec_r, vec_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [7:0]  fail_r, fail_s;
    logic [6:0]  ffv_r, ffv_s;
    logic        ffvalid_r, ffvalid_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        pass_r, pass_s;
    logic        launch_s;
    logic        sample_s;
    logic        mismatch_s;

    // Decode the two events shared by the FSM and the signature datapath.
    always_comb begin
        launch_s   = 1'b0;
        sample_s   = 1'b0;
        mismatch_s = dut_y ^ EXPECTED[vec_r];
        if ((state_r == IDLE) || (state_r == DONE)) begin
            launch_s = start;
        end else begin
            launch_s = 1'b0;
        end
        if ((state_r == RUN) && (cnt_r == 4'd0)) begin
            sample_s = 1'b1;
        end else begin
            sample_s = 1'b0;
        end
    end

    // Next-state and next-output logic for the sweep controller.
    always_comb begin
        state_s   = state_r;
        vec_s     = vec_r;
        cnt_s     = cnt_r;
        fail_s    = fail_r;
        ffv_s     = ffv_r;
        ffvalid_s = ffvalid_r;
        case (state_r)
            IDLE, DONE: begin
                if (launch_s) begin
                    state_s   = RUN;
                    vec_s     = 7'd0;
                    cnt_s     = SETTLE_M1;
                    fail_s    = 8'd0;
                    ffv_s     = 7'd0;
                    ffvalid_s = 1'b0;
                end else if (state_r == IDLE) begin
                    fail_s    = 8'd0;
                    ffv_s     = 7'd0;
                    ffvalid_s = 1'b0;
                end else begin
                    state_s = DONE;
                end
            end
            RUN: begin
                if (!sample_s) begin
                    cnt_s = cnt_r - 4'd1;
                end else begin
                    if (mismatch_s) begin
                        fail_s = fail_r + 8'd1;
                        // Only the earliest mismatch is recorded.
                        if (!ffvalid_r) begin
                            ffv_s     = vec_r;
                            ffvalid_s = 1'b1;
                        end else begin
                            ffvalid_s = 1'b1;
                        end
                    end else begin
                        fail_s = fail_r;
                    end
                    if (vec_r != LAST_VEC) begin
                        vec_s = vec_r + 7'd1;
                        cnt_s = SETTLE_M1;
                    end else begin
                        // vec doubles as the stimulus register, so clearing
                        // it here returns A..G to 0 in DONE.
                        state_s = DONE;
                        vec_s   = 7'd0;
                        cnt_s   = 4'd0;
                    end
                end
            end
            default: begin
                state_s   = IDLE;
                vec_s     = 7'd0;
                cnt_s     = 4'd0;
                fail_s    = 8'd0;
                ffv_s     = 7'd0;
                ffvalid_s = 1'b0;
            end
        endcase
        busy_s = (state_s == RUN);
        done_s = (state_s == DONE);
        pass_s = (state_s == DONE) && (fail_s == 8'd0);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            vec_r     <= 7'd0;
            cnt_r     <= 4'd0;
            fail_r    <= 8'd0;
            ffv_r     <= 7'd0;
            ffvalid_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            vec_r     <= vec_s;
            cnt_r     <= cnt_s;
            fail_r    <= fail_s;
            ffv_r     <= ffv_s;
            ffvalid_r <= ffvalid_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            pass_r    <= pass_s;
        end
    end

`ifdef EXHAUSTIVE_TESTER_SIGNATURE_EN
    // One serial CRC-16/CCITT step over a single response bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] sig, input logic bit_in);
        logic fb;
        fb = sig[15] ^ bit_in;
        return {sig[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    logic [15:0] sig_r, sig_s;

    // Signature next value: seed on launch and fold in each sampled Y.
    always_comb begin
        sig_s = sig_r;
        if (launch_s) begin
            sig_s = 16'hFFFF;
        end else if (sample_s) begin
            sig_s = crc16_step(sig_r, dut_y);
        end else begin
            sig_s = sig_r;
        end
    end

    // Signature register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_r <= 16'h0000;
        end else begin
            sig_r <= sig_s;
        end
    end

    assign signature = sig_r;
`else
    assign signature = 16'h0000;
`endif

    assign {A, B, C, D, E, F, G} = vec_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign pass             = pass_r;
    assign fail_count       = fail_r;
    assign first_fail_vec   = ffv_r;
    assign first_fail_valid = ffvalid_r;

endmodule

// File: tb/tb_week6_ex1_exhaustive_tester.sv
// Scoreboard bench for week6_ex1_exhaustive_tester. The bench plays the
// circuit under test through several response modes. At each launch, a
// reference model works out the expected sweep result from the truth tables
// and pushes it to a queue. A monitor pops an entry on every done rising
// edge and compares it with the DUT outputs.
module tb_week6_ex1_exhaustive_tester;

    localparam int unsigned  SETTLE  = 2;
    localparam logic [127:0] EXP_TBL = {1'b1, 127'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dut_y;
    logic        A, B, C, D, E, F, G;
    logic        busy, done, pass;
    logic [7:0]  fail_count;
    logic [6:0]  first_fail_vec;
    logic        first_fail_valid;
    logic [15:0] signature;

    logic [6:0]   stim;
    int           mode = 0;
    logic [127:0] rnd_tbl = 128'h0;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic         done_seen = 1'b0;

    typedef struct {
        int          fails;
        int          ffv;
        logic        ffvalid;
        logic [15:0] sig;
        int          tstart;
    } exp_t;

    exp_t sb_q[$];

    week6_ex1_exhaustive_tester #(
        .EXPECTED(EXP_TBL),
        .SETTLE  (SETTLE)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .dut_y           (dut_y),
        .A               (A),
        .B               (B),
        .C               (C),
        .D               (D),
        .E               (E),
        .F               (F),
        .G               (G),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .fail_count      (fail_count),
        .first_fail_vec  (first_fail_vec),
        .first_fail_valid(first_fail_valid),
        .signature       (signature)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign stim = {A, B, C, D, E, F, G};

    // Circuit-under-test behaviour for each mode.
    function automatic logic resp(input int m, input logic [6:0] v, input logic [127:0] tbl);
        case (m)
            0: return 1'b0;
            1: return 1'b1;
            2: return &v;
            3: return (&v) ^ (v == 7'h55);
            default: return tbl[v];
        endcase
    endfunction

    always_comb dut_y = resp(mode, stim, rnd_tbl);

    function automatic logic [15:0] crc_model(input logic [127:0] stream);
        logic [15:0] s;
        logic        fb;
        s = 16'hFFFF;
        for (int v = 0; v < 128; v++) begin
            fb = s[15] ^ stream[v];
            s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
`ifdef EXHAUSTIVE_TESTER_SIGNATURE_EN
        return s;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: walk all 128 vectors and tally the mismatches.
    function automatic exp_t model(input int m, input logic [127:0] tbl);
        exp_t         e;
        logic [127:0] stream;
        logic         r;
        e.fails   = 0;
        e.ffv     = 0;
        e.ffvalid = 1'b0;
        e.tstart  = 0;
        stream    = 128'h0;
        for (int v = 0; v < 128; v++) begin
            r         = resp(m, 7'(v), tbl);
            stream[v] = r;
            if (r != EXP_TBL[v]) begin
                if (!e.ffvalid) begin
                    e.ffv     = v;
                    e.ffvalid = 1'b1;
                end
                e.fails++;
            end
        end
        e.sig = crc_model(stream);
        return e;
    endfunction

    // Monitor: compare against the scoreboard on every done rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_seen) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("done_latency", 32'(cyc - e.tstart), 32'(128 * SETTLE));
                check("fail_count", 32'(fail_count), 32'(e.fails));
                check("first_fail_valid", 32'(first_fail_valid), 32'(e.ffvalid));
                check("first_fail_vec", 32'(first_fail_vec), 32'(e.ffv));
                check("pass", 32'(pass), 32'(e.fails == 0));
                check("signature", 32'(signature), 32'(e.sig));
                check("busy_at_done", 32'(busy), 32'd0);
                check("stim_at_done", 32'(stim), 32'd0);
            end
        end
        done_seen = done;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_fail_count"}, 32'(fail_count), 32'd0);
        check({tag, "_ffv"}, 32'(first_fail_vec), 32'd0);
        check({tag, "_ffvalid"}, 32'(first_fail_valid), 32'd0);
        check({tag, "_signature"}, 32'(signature), 32'd0);
        check({tag, "_stim"}, 32'(stim), 32'd0);
    endtask

    // One full sweep; optionally pulse start randomly while it runs.
    task automatic run_sweep(input int m, input bit noisy);
        exp_t e;
        bit   got;
        @(negedge clk);
        mode = m;
        if (m == 4) rnd_tbl = {$urandom, $urandom, $urandom, $urandom};
        e = model(m, rnd_tbl);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.tstart = cyc;
        sb_q.push_back(e);
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_after_start", 32'(done), 32'd0);
        check("stim_after_start", 32'(stim), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            start = noisy ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        start = 1'b0;
        if (!got) begin
            check("sweep_timeout", 32'd1, 32'd0);
            if (sb_q.size() != 0) void'(sb_q.pop_back());
        end
    endtask

    initial begin
        bit hit;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("reset");

        run_sweep(0, 1'b0);   // all zeros: a single miss at vector 127
        run_sweep(1, 1'b0);   // all ones: 127 misses, first at 0
        run_sweep(2, 1'b0);   // AND of all inputs: clean pass
        run_sweep(3, 1'b0);   // AND with a fault at 0x55
        run_sweep(2, 1'b1);   // start pulses during RUN are ignored
        for (int k = 0; k < 3; k++) run_sweep(4, 1'b0);

        // Abort a sweep while vector 40 is on the pins.
        @(negedge clk);
        mode  = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (stim == 7'd40) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reached_vec40", 32'(hit), 32'd1);
        check("partial_fails_nonzero", 32'(fail_count != 8'd0), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("midreset");
        repeat (5) @(posedge clk);
        #1;
        check("idle_stays_idle", 32'(busy), 32'd0);
        run_sweep(3, 1'b0);
        run_sweep(0, 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/week6_ex1_exhaustive_tester.md
# week6_ex1_exhaustive_tester

Self-checking exhaustive stimulus/response engine for the 7-input, 1-output combinational exercise circuits (inputs A–G, output Y). It drives all 128 input combinations into a combinational circuit under test and samples its Y back. It compares each Y against a golden truth table and reports pass/fail counts, so the check runs in hardware instead of by eye from printed vectors. It sits beside a combinational exercise module, wired port-for-port to its A–G/Y.

## Interface
- `EXPECTED`, 128'h0: golden truth table; bit n = expected Y for input vector n.
- `SETTLE`, 2: cycles each vector is held before Y is sampled; legal range 1–15.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep; sampled only in IDLE or DONE.
- `dut_y` in 1: Y returned from the circuit under test.
- `A`,`B`,`C`,`D`,`E`,`F`,`G` out 1 each: stimulus; A = vec[6] … G = vec[0].
- `busy` out 1: sweep in progress.
- `done` out 1: sweep complete; held until `start` or `rst`.
- `pass` out 1: `done` && `fail_count` == 0.
- `fail_count` out 8: number of mismatching vectors, 0–128.
- `first_fail_vec` out 7: vector index of the first mismatch.
- `first_fail_valid` out 1: `first_fail_vec` holds a captured value.
- `signature` out 16: response signature (see Configuration).

## Operation
- All outputs are registered. Reset value of every output is 0, including A–G, which give vector 0.
- Internal state:
  - 7-bit vector counter `vec`.
  - 4-bit settle counter `cnt`.
  - FSM with states IDLE, RUN, DONE.
- IDLE:
  - `start`=1 → RUN, with `vec`=0, `cnt`=SETTLE-1.
  - Clear `fail_count`, `first_fail_*` and `signature` (see Configuration for its seed).
- RUN:
  - `busy`=1; A–G = `vec`.
  - When `cnt`≠0: decrement `cnt`.
  - When `cnt`==0: sample `dut_y` and compare it with EXPECTED[`vec`].
    - On mismatch: `fail_count`++.
    - On the first mismatch only: latch `first_fail_vec`=`vec` and set `first_fail_valid`=1.
  - After the sample, if `vec`≠127: `vec`++ and `cnt`=SETTLE-1.
  - If `vec`==127: → DONE.
- DONE:
  - `busy`=0, `done`=1.
  - A–G return to 0.
  - Results hold.
  - `start`=1 → RUN, behaving exactly as from IDLE.
- `start` during RUN is ignored.
- `rst` has priority over everything. `rst` mid-sweep returns to IDLE with all outputs 0 after that edge, and no partial results survive.
- Vector ordering is strictly ascending 0→127 with no wrap. `fail_count` cannot overflow (max 128 < 256).

## Timing
- Reference point: `start` sampled at edge t.
- After edge t: `busy`=1, A–G = 0.
- Vector n is sampled at edge t+(n+1)·SETTLE and is driven for exactly SETTLE cycles.
- The last sample occurs at edge t+128·SETTLE. After that edge: `done`=1, `busy`=0, and final `fail_count`/`pass`/`signature` are valid.
- `pass` is valid only while `done`=1; otherwise it is 0.
- A restart from DONE clears `done` on the edge that samples `start`.

## Configuration
- `EXHAUSTIVE_TESTER_SIGNATURE_EN` defined:
  - `signature` is a 16-bit serial CRC over the Y stream, polynomial 0x1021.
  - Seed 16'hFFFF on start.
  - At each sample: `fb` = sig[15]^`dut_y`; sig ← {sig[14:0],1'b0} ^ (`fb` ? 16'h1021 : 0).
  - Value is valid with `done`.
- Macro undefined: the `signature` port remains and is constant 16'h0000; no CRC logic is built.

## Test plan
- EXPECTED=0, `dut_y` tied 0, SETTLE=2, pulse `start` → `done` after exactly 256 cycles, `fail_count`=0, `pass`=1, `first_fail_valid`=0.
- EXPECTED=0, `dut_y` tied 1 → `fail_count`=128, `pass`=0, `first_fail_vec`=0, `first_fail_valid`=1.
- EXPECTED = bit 127 only, `dut_y` = A&B&C&D&E&F&G via the bench → `pass`=1. Then force `dut_y` inverted only at vector 0x55 → `fail_count`=1, `first_fail_vec`=0x55.
- Assert `rst` for one cycle while vector 40 is driven → all outputs 0 after the edge, FSM in IDLE. A subsequent `start` completes a normal sweep with correct results.
- Pulse `start` repeatedly during RUN → ignored, and `done` timing stays unchanged. Pulse `start` in DONE → counters clear and a new sweep begins.
- With `EXHAUSTIVE_TESTER_SIGNATURE_EN` and `dut_y` tied 0 → `signature` equals the bench model's CRC of 128 zeros from seed FFFF. Without the macro → `signature`=0.
